// File: rtl/uint_limb_carry_sequencer.sv
// rtl/uint_limb_carry_sequencer.sv - word-serial multi-precision adder front end
//
// Streams LIMBS-limb unsigned operands (LSB limb first, one limb per cycle)
// through an external WIDTH-bit carry-in/carry-out adder. Each limb sum is
// registered in a one-entry output stage, and the adder carry-out is latched
// to become the carry-in of the next limb.
//
// Ports:
//   CLK, ASYNCRESETN        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready       input limb handshake; in_a/in_b limbs, in_cin (limb 0 only)
//   abort                   drops the current transaction at the next edge
//   add_I0/add_I1/add_CIN   drive to the downstream adder
//   add_O/add_COUT          result from the downstream adder
//   out_valid/out_ready     result limb handshake; out_sum, out_last, out_cout
//   busy                    a transaction is partially accepted
module uint_limb_carry_sequencer #(
  parameter int WIDTH = 3,
  parameter int LIMBS = 4
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             abort,
  output logic [WIDTH-1:0] add_I0,
  output logic [WIDTH-1:0] add_I1,
  output logic             add_CIN,
  input  logic [WIDTH-1:0] add_O,
  input  logic             add_COUT,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_last,
  output logic             out_cout,
  output logic             busy
);

  localparam int IW = (LIMBS > 1) ? $clog2(LIMBS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(LIMBS - 1);

  // The limb index is the FSM state: zero is IDLE, anything else is BUSY.
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_last_q, out_last_d;
  logic             out_cout_q, out_cout_d;

  logic accept;
  logic is_last;

  // State register
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      idx_q       <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_last_q  <= out_last_d;
      out_cout_q  <= out_cout_d;
    end
  end

  // Next-state logic
  always_comb begin
    idx_d       = idx_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_last_d  = out_last_q;
    out_cout_d  = out_cout_q;
    is_last     = (idx_q == LAST_IDX);
    accept      = in_valid & in_ready;

    // Draining the output register is independent of abort, so a pending
    // limb survives an abort until the consumer takes it.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (abort) begin
      idx_d   = '0;
      carry_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_sum_d   = add_O;
      out_last_d  = is_last;
      out_cout_d  = is_last ? add_COUT : 1'b0;
      carry_d     = add_COUT;
      idx_d       = is_last ? '0 : idx_q + IW'(1);
    end
  end

  // Output logic
  always_comb begin
    // A new limb may enter whenever the output slot is empty or being emptied
    // this cycle; abort blocks intake so it always wins over accept.
    in_ready = (!out_valid_q || out_ready) && !abort;
    add_I0   = in_a;
    add_I1   = in_b;
    // Limb 0 takes the caller's carry, so no carry leaks across transactions.
    add_CIN  = (idx_q == '0) ? in_cin : carry_q;
    busy     = (idx_q != '0);
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_last  = out_last_q;
  assign out_cout  = out_cout_q;

endmodule
